// File: rtl/mem_access_unit.sv
// mem_access_unit: sub-word load/store adapter in front of a word-only data memory.
// Loads and word stores complete in one cycle. Byte/half stores run a two-cycle
// read-modify-write and stall the pipeline during the read cycle. Misaligned or
// inaccessible requests come back as a fault, and memory is never written for them.
module mem_access_unit #(
    parameter bit LITTLE_ENDIAN = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    input  logic        req_wr,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        done,
    output logic        fault,
    output logic [31:0] load_data,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_acc
);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        RMW_WR = 1'b1
    } state_t;

    state_t      r_state;
    logic [31:0] r_lat_addr;
    logic [31:0] r_lat_wdata;
    logic [1:0]  r_lat_size;
    logic [31:0] r_merge_word;

    logic        w_misaligned;
    logic        w_rmw_start;

    // Byte lane selected by the low address bits. Big-endian memory puts byte 0 in the top lane.
    function automatic logic [1:0] byte_lane(input logic [1:0] a);
        return LITTLE_ENDIAN ? a : ~a;
    endfunction

    // Half lane selected by addr[1]. Big-endian memory puts half 0 in the top lane.
    function automatic logic half_lane(input logic a1);
        return LITTLE_ENDIAN ? a1 : ~a1;
    endfunction

    // Pick the addressed byte or half out of the memory word, then sign- or zero-extend it.
    function automatic logic [31:0] extract_load(input logic [31:0] word,
                                                 input logic [1:0]  a,
                                                 input logic [1:0]  size,
                                                 input logic        sgn);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{byte_lane(a), 3'b000} +: 8];
        h = word[{half_lane(a[1]), 4'b0000} +: 16];
        case (size)
            SZ_BYTE: return {{24{sgn & b[7]}}, b};
            SZ_HALF: return {{16{sgn & h[15]}}, h};
            default: return word;
        endcase
    endfunction

    // Overwrite the addressed byte or half of the old word with the right-justified store data.
    function automatic logic [31:0] merge_store(input logic [31:0] word,
                                                input logic [1:0]  a,
                                                input logic [1:0]  size,
                                                input logic [31:0] wdata);
        logic [31:0] r;
        r = word;
        case (size)
            SZ_BYTE: r[{byte_lane(a), 3'b000} +: 8]     = wdata[7:0];
            SZ_HALF: r[{half_lane(a[1]), 4'b0000} +: 16] = wdata[15:0];
            default: r = wdata;
        endcase
        return r;
    endfunction

    assign w_misaligned = (req_size == 2'b11) ||
                          ((req_size == SZ_HALF) && req_addr[0]) ||
                          ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));

    assign w_rmw_start = (r_state == IDLE) && req_valid && req_wr && !w_misaligned &&
                         (req_size != SZ_WORD) && mem_acc;

    // Build the memory strobes and the CPU handshake from the current state and the live request.
    always_comb begin
        // NOTE: every output gets a default first, so no path through the case leaves one unassigned and infers a latch.
        stall     = 1'b0;
        done      = 1'b0;
        fault     = 1'b0;
        load_data = 32'h0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    mem_addr = {req_addr[31:2], 2'b00};
                    if (w_misaligned) begin
                        done  = 1'b1;
                        fault = 1'b1;
                    end else if (!req_wr) begin
                        mem_rd = 1'b1;
                        done   = 1'b1;
                        fault  = ~mem_acc;
                        if (mem_acc) begin
                            load_data = extract_load(mem_rdata, req_addr[1:0], req_size, req_signed);
                        end
                    end else if (req_size == SZ_WORD) begin
                        mem_wr    = mem_acc;
                        mem_wdata = req_wdata;
                        done      = 1'b1;
                        fault     = ~mem_acc;
                    end else if (mem_acc) begin
                        // Read half of the RMW: fetch the old word, hold the CPU for one cycle.
                        mem_rd = 1'b1;
                        stall  = 1'b1;
                    end else begin
                        done  = 1'b1;
                        fault = 1'b1;
                    end
                end
            end
            RMW_WR: begin
                // Write half of the RMW: driven purely from latched state; req_* is ignored.
                mem_addr  = {r_lat_addr[31:2], 2'b00};
                mem_wr    = 1'b1;
                mem_wdata = merge_store(r_merge_word, r_lat_addr[1:0], r_lat_size, r_lat_wdata);
                done      = 1'b1;
            end
            default: ;
        endcase
    end

    // Sequence the RMW: capture the request and the old word, then spend exactly one cycle writing.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_lat_addr   <= 32'h0;
            r_lat_wdata  <= 32'h0;
            r_lat_size   <= 2'b00;
            r_merge_word <= 32'h0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_rmw_start) begin
                        // NOTE: non-blocking assignments so every latch samples pre-edge values together.
                        r_lat_addr   <= req_addr;
                        r_lat_wdata  <= req_wdata;
                        r_lat_size   <= req_size;
                        r_merge_word <= mem_rdata;
                        r_state      <= RMW_WR;
                    end
                end
                RMW_WR:  r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
